multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM of the multicycle CPU. Sequences fetch/decode/execute/memory/writeback and
//  drives every datapath mux select (IorD, ALUSrcA, ALUSrcB, MemtoReg, PCSource) plus the
//  register/memory write enables. Memory accesses stall on a ready handshake.
//  Pulses InstrDone in the final cycle of each instruction.
// PARAMETERS
//  OP_WIDTH   6   opcode field width (IR[31:26])
// PORTS
//  Clk          in   1  clock; all state updates on rising edge
//  Rst_n        in   1  asynchronous, active-low reset
//  Opcode       in   6  IR[31:26], valid from DECODE onward
//  Zero         in   1  ALU zero flag, sampled in BRANCH
//  MemReady     in   1  memory completes the current MemRead/MemWrite this cycle
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load qualified by Zero (datapath ANDs it)
//  IorD         out  1  0 = PC addresses memory, 1 = ALUOut
//  MemRead      out  1  memory read request, held until MemReady
//  MemWrite     out  1  memory write request, held until MemReady
//  IRWrite      out  1  load instruction register
//  RegDst       out  1  0 = rt, 1 = rd
//  RegWrite     out  1  register file write enable
//  MemtoReg     out  2  writeback 4:1 select: 0 ALUOut, 1 MDR, 2 imm (LI), 3 imm<<16 (LUI)
//  ALUSrcA      out  1  0 = PC, 1 = regA
//  ALUSrcB      out  2  0 = regB, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
//  ALUOp        out  2  0 add, 1 sub, 2 funct-decoded
//  PCSource     out  2  0 ALU result, 1 ALUOut, 2 jump target, 3 exception vector
//  InstrDone    out  1  one-cycle pulse on last state of an instruction
//  Trap         out  1  illegal-opcode trap pulse (ILLEGAL_TRAP_EN only; else tied 0)
// BEHAVIOUR
//  - Moore outputs, registered state; outputs are pure decode of current state.
//  - Reset (Rst_n=0, async): state=FETCH; all outputs 0 except in FETCH decode below, which
//    applies only after first rising edge with Rst_n=1 (outputs forced 0 while Rst_n=0).
//  - States and transitions:
//    FETCH : MemRead=1,IorD=0,ALUSrcA=0,ALUSrcB=1,ALUOp=0; on MemReady: IRWrite=1,PCWrite=1,
//            PCSource=0, ->DECODE; else stay (IRWrite/PCWrite 0 while waiting)
//    DECODE: ALUSrcA=0,ALUSrcB=3,ALUOp=0 (branch target); by Opcode: LW/SW->MEMADR,
//            RTYPE->EXEC, BEQ->BRANCH, J->JUMP, LI/LUI->IMMWB, other->see CONFIGURATION
//    MEMADR: ALUSrcA=1,ALUSrcB=2,ALUOp=0; LW->MEMRD, SW->MEMWR
//    MEMRD : MemRead=1,IorD=1; MemReady->MEMWB else stay
//    MEMWB : RegWrite=1,RegDst=0,MemtoReg=1,InstrDone=1 ->FETCH
//    MEMWR : MemWrite=1,IorD=1; MemReady: InstrDone=1 ->FETCH else stay
//    EXEC  : ALUSrcA=1,ALUSrcB=0,ALUOp=2 ->ALUWB
//    ALUWB : RegWrite=1,RegDst=1,MemtoReg=0,InstrDone=1 ->FETCH
//    BRANCH: ALUSrcA=1,ALUSrcB=0,ALUOp=1,PCWriteCond=1,PCSource=1,InstrDone=1 ->FETCH
//    JUMP  : PCWrite=1,PCSource=2,InstrDone=1 ->FETCH
//    IMMWB : RegWrite=1,RegDst=0,MemtoReg=2 (LI) or 3 (LUI),InstrDone=1 ->FETCH
//  - Opcode latched in DECODE into an internal register; later states use the latched copy.
//  - Cycle counts (MemReady=1 always): LW 5, SW 4, R 4, BEQ 3, J 3, LI/LUI 3.
//  - MemReady outside FETCH/MEMRD/MEMWR is ignored. Rst_n low mid-instruction aborts to
//    FETCH immediately; no partial write enable may be asserted while Rst_n=0.
//  - Illegal state encodings recover to FETCH next cycle.
// CONFIGURATION
//  `ILLEGAL_TRAP_EN defined: unknown opcode in DECODE ->TRAP state: PCWrite=1,PCSource=3,
//   Trap=1,InstrDone=1 ->FETCH. Undefined: unknown opcode treated as NOP, InstrDone=1 in
//   DECODE ->FETCH; Trap tied 0.
// STRUCTURE
//  - Package mc_pkg: opcode constants (OP_RTYPE 6'h00, OP_J 6'h02, OP_BEQ 6'h04,
//    OP_LUI 6'h0F, OP_LI 6'h1F, OP_LW 6'h23, OP_SW 6'h2B), state encodings, MemtoReg/
//    ALUSrcB/PCSource/ALUOp select constants.
//  - Single module; next-state logic and output decode as separate always blocks. No sub-module.
// TESTING
//  - Reset mid-MEMRD (Rst_n low 1 cycle) -> state FETCH, all enables 0, MemRead=1 after release.
//  - LW, MemReady=1 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite=1,MemtoReg=1 in cycle 5, InstrDone once.
//  - SW with MemReady low 3 cycles in MEMWR -> MemWrite,IorD held 4 cycles, no RegWrite, InstrDone on ready.
//  - LUI (6'h0F) -> MemtoReg=3,RegWrite=1 in cycle 3; LI (6'h1F) -> MemtoReg=2.
//  - BEQ -> cycle 3 PCWriteCond=1,PCSource=1,ALUOp=1; J -> PCWrite=1,PCSource=2.
//  - Opcode 6'h3F: with ILLEGAL_TRAP_EN Trap=1,PCSource=3 in cycle 3; without, back to FETCH after DECODE.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle CPU controller: opcodes, FSM states
// and datapath mux select encodings.
package mc_pkg;

  localparam int OP_WIDTH = 6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LI    = 6'h1F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IMMWB  = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [1:0] MTR_ALUOUT = 2'd0;
  localparam logic [1:0] MTR_MDR    = 2'd1;
  localparam logic [1:0] MTR_IMM    = 2'd2;
  localparam logic [1:0] MTR_IMMHI  = 2'd3;

  localparam logic [1:0] SRCB_REGB  = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_EXC    = 2'd3;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction/status inputs to the FSM and
// every mux select and write enable it drives.
interface multicycle_ctrl_if #(parameter int OP_WIDTH = 6);
  logic [OP_WIDTH-1:0] opcode;
  logic                zero;
  logic                mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       reg_write;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       trap;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, trap
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, trap
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU main control FSM; outputs decode current state (plus mem_ready in memory states).
// Latency 3-5 cycles per instruction; memory states hold their request until mem_ready.
// Optional ILLEGAL_TRAP_EN routes unknown opcodes to a trap state instead of a NOP.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int OP_WIDTH = mc_pkg::OP_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  multicycle_ctrl_if.master  bus
);

  state_t              state_q, state_d, dec_tgt;
  logic [OP_WIDTH-1:0] opc_q;
  logic                run_q;

  logic       pcw, pcwc, iord, mrd, mwr, irw, rdst, rwr, srca, done, trp;
  logic [1:0] mtr, srcb, aluop, pcsrc;

  // run_q holds the machine idle (outputs 0, no transitions) until the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      state_q <= run_q ? state_d : S_FETCH;
      if (run_q && state_q == S_DECODE)
        opc_q <= bus.opcode;
    end
  end

  always_comb begin
    dec_tgt = S_FETCH;
    case (bus.opcode)
      OP_WIDTH'(OP_LW), OP_WIDTH'(OP_SW): dec_tgt = S_MEMADR;
      OP_WIDTH'(OP_RTYPE):                dec_tgt = S_EXEC;
      OP_WIDTH'(OP_BEQ):                  dec_tgt = S_BRANCH;
      OP_WIDTH'(OP_J):                    dec_tgt = S_JUMP;
      OP_WIDTH'(OP_LI), OP_WIDTH'(OP_LUI): dec_tgt = S_IMMWB;
`ifdef ILLEGAL_TRAP_EN
      default:                            dec_tgt = S_TRAP;
`else
      default:                            dec_tgt = S_FETCH;
`endif
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = dec_tgt;
      S_MEMADR: state_d = (opc_q == OP_WIDTH'(OP_SW)) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pcw = 1'b0; pcwc = 1'b0; iord = 1'b0; mrd = 1'b0; mwr = 1'b0; irw = 1'b0;
    rdst = 1'b0; rwr = 1'b0; srca = 1'b0; done = 1'b0; trp = 1'b0;
    mtr = MTR_ALUOUT; srcb = SRCB_REGB; aluop = ALUOP_ADD; pcsrc = PCS_ALU;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          mrd  = 1'b1;
          srcb = SRCB_FOUR;
          irw  = bus.mem_ready;
          pcw  = bus.mem_ready;
        end
        S_DECODE: begin
          srcb = SRCB_IMMSH;
          done = (dec_tgt == S_FETCH);
        end
        S_MEMADR: begin srca = 1'b1; srcb = SRCB_IMM; end
        S_MEMRD:  begin mrd = 1'b1; iord = 1'b1; end
        S_MEMWB:  begin rwr = 1'b1; mtr = MTR_MDR; done = 1'b1; end
        S_MEMWR:  begin mwr = 1'b1; iord = 1'b1; done = bus.mem_ready; end
        S_EXEC:   begin srca = 1'b1; aluop = ALUOP_FUNCT; end
        S_ALUWB:  begin rwr = 1'b1; rdst = 1'b1; done = 1'b1; end
        S_BRANCH: begin
          srca  = 1'b1;
          aluop = ALUOP_SUB;
          pcwc  = 1'b1;
          pcsrc = PCS_ALUOUT;
          done  = 1'b1;
        end
        S_JUMP:   begin pcw = 1'b1; pcsrc = PCS_JUMP; done = 1'b1; end
        S_IMMWB: begin
          rwr  = 1'b1;
          mtr  = (opc_q == OP_WIDTH'(OP_LI)) ? MTR_IMM : MTR_IMMHI;
          done = 1'b1;
        end
`ifdef ILLEGAL_TRAP_EN
        S_TRAP: begin pcw = 1'b1; pcsrc = PCS_EXC; trp = 1'b1; done = 1'b1; end
`endif
        default: ;
      endcase
    end
  end

  assign bus.pc_write      = pcw;
  assign bus.pc_write_cond = pcwc;
  assign bus.iord          = iord;
  assign bus.mem_read      = mrd;
  assign bus.mem_write     = mwr;
  assign bus.ir_write      = irw;
  assign bus.reg_dst       = rdst;
  assign bus.reg_write     = rwr;
  assign bus.mem_to_reg    = mtr;
  assign bus.alu_src_a     = srca;
  assign bus.alu_src_b     = srcb;
  assign bus.alu_op        = aluop;
  assign bus.pc_source     = pcsrc;
  assign bus.instr_done    = done;
  assign bus.trap          = trp;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle check of the full control word.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {pcw,pcwc,iord,mrd,mwr,irw,rdst,rwr, mtr, srca, srcb, aluop, pcsrc, done, trap}
  logic [18:0] obs;
  assign obs = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.reg_dst, bus.reg_write, bus.mem_to_reg, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source, bus.instr_done, bus.trap};

  localparam logic [18:0] E_ZERO     = 19'd0;
  localparam logic [18:0] E_FWAIT    = {8'b0001_0000, 2'd0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0};
  localparam logic [18:0] E_FGO      = {8'b1001_0100, 2'd0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0};
  localparam logic [18:0] E_DECODE   = {8'b0000_0000, 2'd0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0};
  localparam logic [18:0] E_DEC_NOP  = {8'b0000_0000, 2'd0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0};
  localparam logic [18:0] E_MEMADR   = {8'b0000_0000, 2'd0, 1'b1, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0};
  localparam logic [18:0] E_MEMRD    = {8'b0011_0000, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0};
  localparam logic [18:0] E_MEMWB    = {8'b0000_0001, 2'd1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0};
  localparam logic [18:0] E_MEMWR    = {8'b0010_1000, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0};
  localparam logic [18:0] E_MEMWR_OK = {8'b0010_1000, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0};
  localparam logic [18:0] E_EXEC     = {8'b0000_0000, 2'd0, 1'b1, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0};
  localparam logic [18:0] E_ALUWB    = {8'b0000_0011, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0};
  localparam logic [18:0] E_BRANCH   = {8'b0100_0000, 2'd0, 1'b1, 2'd0, 2'd1, 2'd1, 1'b1, 1'b0};
  localparam logic [18:0] E_JUMP     = {8'b1000_0000, 2'd0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0};
  localparam logic [18:0] E_LI       = {8'b0000_0001, 2'd2, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0};
  localparam logic [18:0] E_LUI      = {8'b0000_0001, 2'd3, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0};
  localparam logic [18:0] E_TRAP     = {8'b1000_0000, 2'd0, 1'b0, 2'd0, 2'd0, 2'd3, 1'b1, 1'b1};

  task automatic chk(input string tag, input logic [18:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp_v);
    end
  endtask

  // Drive inputs just after the falling edge, check before the next rising edge.
  task automatic cyc(input logic rdy, input logic [5:0] op, input string tag,
                     input logic [18:0] exp_v);
    @(negedge clk);
    bus.mem_ready = rdy;
    bus.opcode    = op;
    #1;
    chk(tag, exp_v);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode    = OP_LW;
    bus.zero      = 1'b0;

    cyc(1'b1, OP_LW, "reset_hold", E_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_pre_edge", E_ZERO);

    cyc(1'b0, OP_LW, "fetch_wait0", E_FWAIT);
    cyc(1'b0, OP_LW, "fetch_wait1", E_FWAIT);

    // LW, memory always ready
    cyc(1'b1, OP_LW, "lw_fetch",  E_FGO);
    cyc(1'b1, OP_LW, "lw_decode", E_DECODE);
    cyc(1'b1, OP_RTYPE, "lw_memadr", E_MEMADR);
    cyc(1'b1, OP_RTYPE, "lw_memrd", E_MEMRD);
    cyc(1'b1, OP_RTYPE, "lw_memwb", E_MEMWB);
    cyc(1'b0, OP_RTYPE, "lw_back_fetch", E_FWAIT);

    // SW with three stall cycles in MEMWR
    cyc(1'b1, OP_SW, "sw_fetch",  E_FGO);
    cyc(1'b0, OP_SW, "sw_decode", E_DECODE);
    cyc(1'b0, OP_SW, "sw_memadr", E_MEMADR);
    cyc(1'b0, OP_SW, "sw_stall0", E_MEMWR);
    cyc(1'b0, OP_SW, "sw_stall1", E_MEMWR);
    cyc(1'b0, OP_SW, "sw_stall2", E_MEMWR);
    cyc(1'b1, OP_SW, "sw_ready",  E_MEMWR_OK);
    cyc(1'b0, OP_SW, "sw_back_fetch", E_FWAIT);

    // R-type
    cyc(1'b1, OP_RTYPE, "r_fetch",  E_FGO);
    cyc(1'b1, OP_RTYPE, "r_decode", E_DECODE);
    cyc(1'b1, OP_RTYPE, "r_exec",   E_EXEC);
    cyc(1'b1, OP_RTYPE, "r_aluwb",  E_ALUWB);

    // BEQ and J
    cyc(1'b1, OP_BEQ, "beq_fetch",  E_FGO);
    cyc(1'b1, OP_BEQ, "beq_decode", E_DECODE);
    cyc(1'b1, OP_BEQ, "beq_branch", E_BRANCH);
    cyc(1'b1, OP_J, "j_fetch",  E_FGO);
    cyc(1'b1, OP_J, "j_decode", E_DECODE);
    cyc(1'b1, OP_J, "j_jump",   E_JUMP);

    // LUI then LI; the opcode input changes after DECODE to prove the latched copy is used
    cyc(1'b1, OP_LUI, "lui_fetch",  E_FGO);
    cyc(1'b1, OP_LUI, "lui_decode", E_DECODE);
    cyc(1'b1, OP_LI,  "lui_immwb",  E_LUI);
    cyc(1'b1, OP_LI,  "li_fetch",   E_FGO);
    cyc(1'b1, OP_LI,  "li_decode",  E_DECODE);
    cyc(1'b1, OP_LUI, "li_immwb",   E_LI);

    // Unknown opcode
    cyc(1'b1, 6'h3F, "ill_fetch", E_FGO);
`ifdef ILLEGAL_TRAP_EN
    cyc(1'b0, 6'h3F, "ill_decode", E_DECODE);
    cyc(1'b0, 6'h3F, "ill_trap",   E_TRAP);
`else
    cyc(1'b0, 6'h3F, "ill_decode_nop", E_DEC_NOP);
`endif
    cyc(1'b0, 6'h3F, "ill_back_fetch", E_FWAIT);

    // Reset asserted while stalled in MEMRD
    cyc(1'b1, OP_LW, "rst_lw_fetch",  E_FGO);
    cyc(1'b1, OP_LW, "rst_lw_decode", E_DECODE);
    cyc(1'b0, OP_LW, "rst_lw_memadr", E_MEMADR);
    cyc(1'b0, OP_LW, "rst_lw_memrd",  E_MEMRD);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_memrd", E_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_release", E_ZERO);
    cyc(1'b0, OP_LW, "rst_mid_fetch", E_FWAIT);
    cyc(1'b1, OP_LW, "rst_mid_fetch_go", E_FGO);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
